// File: rtl/loader_pkg.sv
// Shared definitions for the parameter loader: FSM state encoding,
// default BRAM read latency and the layer base addresses in parameter BRAM.
package loader_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // BRAM cycles from en/addr to valid dout on the shared parameter BRAM.
    localparam int RD_LAT_DEFAULT = 2;

    // Word address of the layer-2 bias block in the shared parameter BRAM.
    localparam int unsigned L2_BIAS_BASE = 17088;

endpackage : loader_pkg

// File: rtl/param_loader_if.sv
// Read-only BRAM port between the loader (master) and the BRAM arbiter (slave).
interface param_loader_if #(
    parameter int ADDR_W = 15,
    parameter int W      = 8
) ();

    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      dout;

    // Loader side: issues reads, receives data.
    modport master (
        output en,
        output addr,
        input  dout
    );

    // Arbiter side: accepts reads, returns data.
    modport slave (
        input  en,
        input  addr,
        output dout
    );

endinterface : param_loader_if

// File: rtl/param_loader_rd_lat_pipe.sv
// Valid shift pipe matching the BRAM read latency: a read enable entering
// now emerges as a capture strobe exactly DEPTH cycles later.
module rd_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] stage_q;

    // Shift read enables through the pipe; clear flushes in-flight reads.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every stage read the previous
        // cycle's value, so the loop order does not matter.
        if (clr) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid = stage_q[DEPTH-1];

endmodule : rd_lat_pipe

// File: rtl/param_loader.sv
// Streams a block of up to MAX_WORDS words from the shared parameter BRAM,
// starting at a runtime base address, into one packed vector for a
// downstream layer. One read per cycle; returns are captured when the
// latency pipe says the BRAM data for that read is on dout.
module param_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = 10,
    parameter int W         = 8,
    parameter int ADDR_W    = 15,
    parameter int CNT_W     = 16,
    parameter int RD_LAT    = RD_LAT_DEFAULT   // legal range 1..4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [CNT_W-1:0]       count,
    output logic                   busy,
    output logic                   done,
    output logic                   data_valid,
    output logic                   err_clamp,
    param_loader_if.master         bram,
    output logic [MAX_WORDS*W-1:0] data_out
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  n_q;        // clamped word count for this load
    logic [CNT_W-1:0]  issued_q;   // reads issued so far
    logic [CNT_W-1:0]  wr_ptr_q;   // words captured so far / next slot
    logic [CNT_W-1:0]  count_clamped;
    logic              accept;
    logic              cap_strobe;
    logic              cap_fire;
    logic              loading;

    assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;
    assign accept        = (state_q == IDLE) && start;
    assign loading       = (state_q == ISSUE) || (state_q == DRAIN);
    // The wr_ptr guard keeps a stray strobe from writing past the block.
    assign cap_fire      = cap_strobe && loading && (wr_ptr_q < n_q);

    // Read-latency tracker; reset flushes reads still in flight.
    rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_lat_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (bram.en),
        .out_valid (cap_strobe)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_d unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issued_q + ONE == n_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_fire && (wr_ptr_q + ONE == n_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy      = loading;
        done      = (state_q == DONE);
        bram.en   = (state_q == ISSUE);
        bram.addr = '0;
        if (state_q == ISSUE) begin
            // Address wraps silently at 2^ADDR_W.
            bram.addr = base_q + ADDR_W'(issued_q);
        end
    end

    // Load bookkeeping and data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            n_q        <= '0;
            issued_q   <= '0;
            wr_ptr_q   <= '0;
            err_clamp  <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else if (accept) begin
            base_q     <= base_addr;
            n_q        <= count_clamped;
            issued_q   <= '0;
            wr_ptr_q   <= '0;
            err_clamp  <= (count > MAX_CNT);
            // An empty load goes straight to DONE, where data_valid must be high.
            data_valid <= (count == '0);
            data_out   <= '0;
        end else begin
            if (state_q == ISSUE) begin
                issued_q <= issued_q + ONE;
            end
            if (cap_fire) begin
                for (int i = 0; i < MAX_WORDS; i++) begin
                    if (wr_ptr_q == CNT_W'(i)) begin
                        data_out[i*W +: W] <= bram.dout;
                    end
                end
                wr_ptr_q <= wr_ptr_q + ONE;
            end
            if (state_d == DONE) begin
                data_valid <= 1'b1;
            end
        end
    end

endmodule : param_loader

// File: tb/tb_param_loader.sv
// Self-checking bench for param_loader: three loaders with read latencies
// 1, 2 and 4, each with its own BRAM model (mem[a] = a[7:0]), driven by
// directed and random loads and compared against a cycle-level model
// derived from the load timing rules.
module tb_param_loader;
    import loader_pkg::*;

    localparam int NI = 3;
    localparam int MW = 10;
    localparam int W  = 8;
    localparam int AW = 15;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a   [NI];
    logic          start_a [NI];
    logic [AW-1:0] base_a  [NI];
    logic [CW-1:0] count_a [NI];
    logic          busy_a  [NI];
    logic          done_a  [NI];
    logic          dv_a    [NI];
    logic          err_a   [NI];
    logic          en_a    [NI];
    logic [AW-1:0] addr_a  [NI];
    logic [MW*W-1:0] data_a [NI];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        param_loader_if #(.ADDR_W(AW), .W(W)) bif ();

        param_loader #(
            .MAX_WORDS (MW),
            .W         (W),
            .ADDR_W    (AW),
            .CNT_W     (CW),
            .RD_LAT    (LAT)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_a[g]),
            .start      (start_a[g]),
            .base_addr  (base_a[g]),
            .count      (count_a[g]),
            .busy       (busy_a[g]),
            .done       (done_a[g]),
            .data_valid (dv_a[g]),
            .err_clamp  (err_a[g]),
            .bram       (bif.master),
            .data_out   (data_a[g])
        );

        // BRAM model: data for an enabled read appears LAT cycles later;
        // garbage otherwise so mistimed captures show up.
        logic [7:0] rd_pipe [4];
        always @(posedge clk) begin
            rd_pipe[0] <= bif.en ? bif.addr[7:0] : 8'($urandom);
            for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign bif.dout  = rd_pipe[LAT-1];
        assign en_a[g]   = bif.en;
        assign addr_a[g] = bif.addr;
    end

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 2 : 4);
    endfunction

    // Expected packed vector: the first 'vis' words of the block (capped at n),
    // word k = low byte of (b + k) mod 2^AW, all other slots zero.
    function automatic logic [MW*W-1:0] exp_data(input int b, input int n, input int vis);
        logic [MW*W-1:0] v;
        int a;
        v = '0;
        for (int k = 0; k < MW; k++) begin
            if (k < n && k < vis) begin
                a = (b + k) % (1 << AW);
                v[k*W +: W] = 8'(a % 256);
            end
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One load on instance idx, starting at a negedge of an IDLE cycle.
    // noise: random start pulses while the load is in progress.
    // chain: assert start (nb/nc) during the done cycle and leave it high.
    task automatic run_load(input int idx, input int b, input int c,
                            input bit noise, input bit chain, input int nb, input int nc);
        int n, lat, done_at, last, vis;
        bit exp_err;
        string t;
        n       = (c > MW) ? MW : c;
        exp_err = (c > MW);
        lat     = lat_of(idx);
        done_at = (n == 0) ? 1 : n + lat + 1;
        last    = chain ? done_at + 1 : done_at + 2;
        start_a[idx] = 1'b1;
        base_a[idx]  = AW'(b);
        count_a[idx] = CW'(c);
        @(posedge clk);
        #1 start_a[idx] = 1'b0;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            t   = $sformatf("lat%0d b=%0h c=%0d cyc%0d", lat, b, c, cyc);
            vis = cyc - 1 - lat;
            check({"bram_en ", t}, en_a[idx], (n > 0 && cyc <= n));
            if (n > 0 && cyc <= n)
                check({"bram_addr ", t}, addr_a[idx], (b + cyc - 1) % (1 << AW));
            check({"busy ", t}, busy_a[idx], (cyc < done_at));
            check({"done ", t}, done_a[idx], (cyc == done_at));
            check({"data_valid ", t}, dv_a[idx], (cyc >= done_at));
            check({"err_clamp ", t}, err_a[idx], exp_err);
            check({"data_out ", t}, data_a[idx], exp_data(b, n, vis));
            if (chain && cyc >= done_at) begin
                start_a[idx] = 1'b1;
                base_a[idx]  = AW'(nb);
                count_a[idx] = CW'(nc);
            end else if (noise && cyc < done_at && $urandom_range(0, 2) == 0) begin
                start_a[idx] = 1'b1;
                base_a[idx]  = AW'($urandom_range(0, (1 << AW) - 1));
                count_a[idx] = CW'($urandom_range(0, 14));
            end else begin
                start_a[idx] = 1'b0;
            end
        end
    endtask

    // Ten-word load on instance idx, reset asserted in cycle T0+5.
    task automatic run_abort(input int idx, input int b);
        string t;
        start_a[idx] = 1'b1;
        base_a[idx]  = AW'(b);
        count_a[idx] = CW'(10);
        @(posedge clk);
        #1 start_a[idx] = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 5) rst_a[idx] = 1'b1;
        end
        @(negedge clk);
        t = $sformatf("abort lat%0d", lat_of(idx));
        check({"busy ", t}, busy_a[idx], 1'b0);
        check({"done ", t}, done_a[idx], 1'b0);
        check({"data_valid ", t}, dv_a[idx], 1'b0);
        check({"err_clamp ", t}, err_a[idx], 1'b0);
        check({"bram_en ", t}, en_a[idx], 1'b0);
        check({"bram_addr ", t}, addr_a[idx], '0);
        check({"data_out ", t}, data_a[idx], '0);
        rst_a[idx] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            t = $sformatf("post-abort lat%0d +%0d", lat_of(idx), k);
            check({"bram_en ", t}, en_a[idx], 1'b0);
            check({"busy ", t}, busy_a[idx], 1'b0);
            check({"data_valid ", t}, dv_a[idx], 1'b0);
            check({"data_out ", t}, data_a[idx], '0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_a[i]   = 1'b1;
            start_a[i] = 1'b0;
            base_a[i]  = '0;
            count_a[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset busy %0d", i), busy_a[i], 1'b0);
            check($sformatf("reset done %0d", i), done_a[i], 1'b0);
            check($sformatf("reset data_valid %0d", i), dv_a[i], 1'b0);
            check($sformatf("reset err_clamp %0d", i), err_a[i], 1'b0);
            check($sformatf("reset bram_en %0d", i), en_a[i], 1'b0);
            check($sformatf("reset data_out %0d", i), data_a[i], '0);
            rst_a[i] = 1'b0;
        end
        @(negedge clk);

        // Directed loads on the RD_LAT=2 instance.
        run_load(1, int'(L2_BIAS_BASE), 10, 1'b0, 1'b0, 0, 0);
        run_load(1, 5, 0, 1'b0, 1'b0, 0, 0);
        run_load(1, 100, 15, 1'b0, 1'b0, 0, 0);
        run_load(1, 200, 3, 1'b0, 1'b0, 0, 0);
        run_load(1, 'h7FFE, 4, 1'b0, 1'b0, 0, 0);
        run_abort(1, 300);
        run_load(1, 400, 10, 1'b0, 1'b0, 0, 0);
        run_load(1, 500, 6, 1'b0, 1'b1, 600, 3);
        run_load(1, 600, 3, 1'b0, 1'b0, 0, 0);

        // Every latency: full block with ignored start pulses, edge cases, random loads.
        for (int i = 0; i < NI; i++) begin
            run_load(i, int'(L2_BIAS_BASE), 10, 1'b1, 1'b0, 0, 0);
            run_load(i, 'h7FFD, 1, 1'b0, 1'b0, 0, 0);
            run_load(i, 50, 15, 1'b1, 1'b1, 'h7FF0, 0);
            run_load(i, 'h7FF0, 0, 1'b0, 1'b0, 0, 0);
            run_abort(i, 1000 + i);
            for (int r = 0; r < 5; r++) begin
                run_load(i, int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, 14)),
                         1'b1, 1'b0, 0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_param_loader
